// File: rtl/sensor_frame_rx.sv
// Receive-side checker for the sensor-emulator LVDS frame protocol: locks to the idle
// pattern, verifies header/data/footer cycle by cycle and streams the recovered pattern.
module sensor_frame_rx #(
   parameter int PATTERN_WIDTH = 32,
   parameter int LVDS_WIDTH    = 512
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [31:0]              cycles_per_frame,
   input  logic [7:0]               idle_0,
   input  logic [7:0]               idle_1,
   input  logic [31:0]              frame_header,
   input  logic                     clear_counters,
   input  logic [LVDS_WIDTH-1:0]    lvds,
   output logic                     locked,
   output logic                     sof,
   output logic                     eof,
   output logic [31:0]              frame_count,
   output logic [31:0]              error_count,
   output logic [31:0]              sync_loss_count,
   output logic [31:0]              drop_count,
   output logic [PATTERN_WIDTH-1:0] M_AXIS_TDATA,
   output logic                     M_AXIS_TUSER,
   output logic                     M_AXIS_TVALID,
   input  logic                     M_AXIS_TREADY
);

   localparam int LVDS_BYTES = LVDS_WIDTH / 8;
   localparam int REPLICAS   = 64 / PATTERN_WIDTH;

   typedef enum logic [2:0] {HUNT, IDLE, HDR, DATA, FTR} state_t;

   function automatic logic [LVDS_WIDTH-1:0] make_ramp();
      logic [LVDS_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < LVDS_BYTES; i++) r[8*i +: 8] = 8'(i);
      return r;
   endfunction

   localparam logic [LVDS_WIDTH-1:0] RAMP = make_ramp();

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t      state, state_next;
   logic [31:0] cyc;
   logic        last_i1, prev_i0, ferr;
   logic [7:0]  slot [8];
   logic [7:0]  b0;
   logic        uniform, u_i0, u_i1, u_hdr;
   logic        start, slip, done, cyc_err, rep_err, frame_err;
   logic [63:0] pattern;

   assign b0        = lvds[7:0];
   assign uniform   = (lvds == {LVDS_BYTES{b0}});
   assign u_i0      = uniform && (b0 == idle_0);
   assign u_i1      = uniform && (b0 == idle_1);
   assign u_hdr     = uniform && (b0 == frame_header[7:0]);
   assign pattern   = {slot[0], slot[1], slot[2], slot[3], slot[4], slot[5], slot[6], slot[7]};
   assign frame_err = ferr | cyc_err | rep_err;

   // Narrow patterns are sent replicated across all eight slots; every replica must agree.
   always_comb begin
      rep_err = 1'b0;
      for (int r = 1; r < REPLICAS; r++)
         if (pattern[r*PATTERN_WIDTH +: PATTERN_WIDTH] != pattern[PATTERN_WIDTH-1:0]) rep_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) state <= HUNT;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         HUNT:    if (prev_i0 && u_i1) state_next = IDLE;
         IDLE:    if (start) state_next = HDR;
                  else if (slip) state_next = HUNT;
         HDR:     if (cyc == 32'd15) state_next = DATA;
         DATA:    if (cyc == cycles_per_frame - 32'd5) state_next = FTR;
         FTR:     if (cyc == cycles_per_frame - 32'd1) state_next = IDLE;
         default: state_next = HUNT;
      endcase
   end

   // Leaving the last footer cycle lands in IDLE as if idle_1 had just been seen,
   // so the next cycle may be either idle_0 or a back-to-back header.
   always_comb begin
      start   = 1'b0;
      slip    = 1'b0;
      done    = 1'b0;
      cyc_err = 1'b0;
      case (state)
         IDLE: begin
            start = last_i1 && u_hdr;
            slip  = !(start || (last_i1 ? u_i0 : u_i1));
         end
         HDR: begin
            if (cyc <= 32'd3)
               cyc_err = !(uniform && (b0 == frame_header[{cyc[1:0], 3'b000} +: 8]));
            else if (cyc == 32'd8)
               cyc_err = (lvds != RAMP);
            else
               cyc_err = (lvds != '0);
         end
         DATA: cyc_err = !uniform ||
                         ((cyc <= 32'd47) && (cyc[1:0] != 2'b00) && (b0 != slot[cyc[4:2]]));
         FTR: begin
            cyc_err = (lvds != '0);
            done    = (cyc == cycles_per_frame - 32'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cyc     <= '0;
         last_i1 <= 1'b0;
         prev_i0 <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         prev_i0 <= (state == HUNT) && u_i0;
         last_i1 <= (state == IDLE) ? !last_i1 : 1'b1;
         if (start) begin
            cyc  <= 32'd1;
            ferr <= 1'b0;
         end else if (state == HDR || state == DATA || state == FTR) begin
            cyc  <= cyc + 32'd1;
            ferr <= ferr | cyc_err;
         end
      end
   end

   // First cycle of each 4-cycle slot group captures; the other three are compared.
   always_ff @(posedge clk) begin
      if (state == DATA && cyc <= 32'd47 && cyc[1:0] == 2'b00) slot[cyc[4:2]] <= b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         locked <= 1'b0;
         sof    <= 1'b0;
         eof    <= 1'b0;
      end else begin
         locked <= (state != HUNT);
         sof    <= start;
         eof    <= done;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || clear_counters) begin
         frame_count     <= '0;
         error_count     <= '0;
         sync_loss_count <= '0;
         drop_count      <= '0;
      end else begin
         if (done)              frame_count     <= sat_inc(frame_count);
         if (done && frame_err) error_count     <= sat_inc(error_count);
         if (slip)              sync_loss_count <= sat_inc(sync_loss_count);
         if (done && M_AXIS_TVALID && !M_AXIS_TREADY) drop_count <= sat_inc(drop_count);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TUSER  <= 1'b0;
      end else if (done && (!M_AXIS_TVALID || M_AXIS_TREADY)) begin
         M_AXIS_TVALID <= 1'b1;
         M_AXIS_TDATA  <= pattern[PATTERN_WIDTH-1:0];
         M_AXIS_TUSER  <= frame_err;
      end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
         M_AXIS_TVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Bench for sensor_frame_rx: builds frames at transaction level, predicts results and
// counters from the frame contents and injected faults, and scoreboards the AXI stream.
module tb_sensor_frame_rx;

   localparam int PW = 32;
   localparam int LW = 512;
   localparam int NB = LW / 8;

   logic          clk = 1'b0;
   logic          resetn, clear_counters, tready;
   logic [31:0]   cpf, hdr;
   logic [7:0]    idle_0, idle_1;
   logic [LW-1:0] lvds;
   logic          locked, sof, eof, tvalid, tuser;
   logic [31:0]   frame_count, error_count, sync_loss_count, drop_count;
   logic [PW-1:0] tdata;

   sensor_frame_rx #(.PATTERN_WIDTH(PW), .LVDS_WIDTH(LW)) dut (
      .clk(clk), .resetn(resetn), .cycles_per_frame(cpf), .idle_0(idle_0), .idle_1(idle_1),
      .frame_header(hdr), .clear_counters(clear_counters), .lvds(lvds), .locked(locked),
      .sof(sof), .eof(eof), .frame_count(frame_count), .error_count(error_count),
      .sync_loss_count(sync_loss_count), .drop_count(drop_count), .M_AXIS_TDATA(tdata),
      .M_AXIS_TUSER(tuser), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [PW-1:0] data; logic user; } res_t;
   res_t exp_q[$];

   int n_checks = 0, n_pass = 0;
   int exp_frames = 0, exp_errs = 0, exp_slips = 0, exp_drops = 0;
   bit rand_rdy = 1'b0;
   int zrun = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [LW-1:0] uni(input logic [7:0] b);
      return {NB{b}};
   endfunction

   function automatic bit rep_mismatch(input logic [63:0] p);
      bit m = 1'b0;
      for (int r = 1; r < 64 / PW; r++) if (p[r*PW +: PW] != p[PW-1:0]) m = 1'b1;
      return m;
   endfunction

   // Bus content the emulator sends on frame cycle c for a 64-bit pattern (slot0 = MSB).
   function automatic logic [LW-1:0] frame_bus(input int c, input logic [63:0] pat, input int cpf_v);
      logic [LW-1:0] v;
      v = '0;
      if (c == 0) v = uni(hdr[7:0]);
      else if (c <= 3) v = uni(hdr[8*c +: 8]);
      else if (c == 8) for (int i = 0; i < NB; i++) v[8*i +: 8] = 8'(i);
      else if (c >= 16 && c <= cpf_v - 5) v = uni(pat[8*(7 - ((c >> 2) & 7)) +: 8]);
      return v;
   endfunction

   task automatic step(input logic [LW-1:0] bus);
      lvds = bus;
      if (rand_rdy) begin
         if (zrun >= 3) tready = 1'b1;
         else tready = ($urandom_range(0, 3) != 0);
         zrun = tready ? 0 : zrun + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_pair();
      step(uni(idle_0));
      step(uni(idle_1));
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_frames"}, frame_count, exp_frames);
      chk({tag, "_errors"}, error_count, exp_errs);
      chk({tag, "_slips"}, sync_loss_count, exp_slips);
      chk({tag, "_drops"}, drop_count, exp_drops);
   endtask

   // kind: 0 clean, 1 one non-uniform byte, 2 wrong uniform value on a repeat slot visit,
   // 3 header byte flip, 4 footer byte flip.  cc/j/nz give where and how to corrupt.
   task automatic send_frame(input logic [63:0] pat, input int kind, input int cc, input int j,
                             input logic [7:0] nz, input int cpf_v, input bit drop);
      logic [LW-1:0] bus;
      bit            err;
      res_t          r;
      cpf = cpf_v;
      for (int c = 0; c < cpf_v; c++) begin
         bus = frame_bus(c, pat, cpf_v);
         if (kind != 0 && c == cc) begin
            if (kind == 2) bus = uni(bus[7:0] ^ nz);
            else bus[8*j +: 8] = bus[8*j +: 8] ^ nz;
         end
         step(bus);
         if (c == 0) chk("sof", sof, 1);
         if (c == 1) chk("sof_pulse", sof, 0);
         if (c == cpf_v - 2) chk("eof_early", eof, 0);
         if (c == cpf_v - 1) chk("eof", eof, 1);
         if (c == 20) chk("locked_in_frame", locked, 1);
      end
      err = (kind != 0) || rep_mismatch(pat);
      exp_frames++;
      if (err) exp_errs++;
      if (drop) exp_drops++;
      else begin
         r.data = pat[PW-1:0];
         r.user = err;
         exp_q.push_back(r);
      end
      check_counters("frame");
   endtask

   always @(negedge clk) begin
      if (resetn && tvalid && tready) begin
         chk("result_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            res_t r;
            r = exp_q.pop_front();
            chk("tdata", tdata, r.data);
            chk("tuser", tuser, r.user);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic [63:0] p;
      int kind, cc, j, cpf_v, gap;
      resetn = 1'b0; clear_counters = 1'b0; tready = 1'b1;
      cpf = 32'd64; idle_0 = 8'hA5; idle_1 = 8'h5A; hdr = 32'h4433_2211; lvds = '0;
      repeat (3) step('0);
      chk("rst_locked", locked, 0);
      chk("rst_sof", sof, 0);
      chk("rst_eof", eof, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tuser", tuser, 0);
      check_counters("rst");
      resetn = 1'b1;

      // idle lock: locked rises two cycles after the first idle_1
      step(uni(8'hA5)); chk("lock_a", locked, 0);
      step(uni(8'h5A)); chk("lock_b", locked, 0);
      step(uni(8'hA5)); chk("lock_c", locked, 1);
      step(uni(8'h5A)); check_counters("lock");

      // reset in the middle of DATA
      for (int c = 0; c <= 30; c++) step(frame_bus(c, 64'hDEADBEEF_DEADBEEF, 64));
      resetn = 1'b0;
      step(frame_bus(31, 64'hDEADBEEF_DEADBEEF, 64));
      resetn = 1'b1;
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_frames", frame_count, 0);
      chk("midrst_locked", locked, 0);
      repeat (3) step(uni(8'h5A));
      chk("hunt_needs_pair", locked, 0);
      idle_pair(); step(uni(8'hA5));
      chk("relock_after_rst", locked, 1);
      step(uni(8'h5A));

      // clean frame
      send_frame(64'hDEADBEEF_DEADBEEF, 0, 0, 0, 8'h00, 64, 1'b0);
      chk("clean_tvalid", tvalid, 1);
      chk("clean_tdata", tdata, 32'hDEADBEEF);
      idle_pair();
      chk("clean_tvalid_drop", tvalid, 0);

      // corrupt byte 5 of cycle 20
      send_frame(64'hCAFEF00D_CAFEF00D, 1, 20, 5, 8'h01, 64, 1'b0);
      chk("corrupt_locked", locked, 1);
      idle_pair();

      // backpressure: second back-to-back result is dropped, first is held
      tready = 1'b0;
      send_frame(64'h13579BDF_13579BDF, 0, 0, 0, 8'h00, 64, 1'b0);
      send_frame(64'h2468ACE0_2468ACE0, 0, 0, 0, 8'h00, 52, 1'b1);
      chk("bp_tvalid", tvalid, 1);
      chk("bp_held", tdata, 32'h13579BDF);
      tready = 1'b1;
      idle_pair();
      chk("bp_drained", tvalid, 0);

      // sync loss in IDLE, then relock
      step(uni(8'hA5));
      step(uni(8'h00));
      exp_slips++;
      chk("slip_count", sync_loss_count, exp_slips);
      step(uni(8'hA5)); chk("slip_unlocked", locked, 0);
      step(uni(8'h5A)); chk("slip_still_unlocked", locked, 0);
      step(uni(8'hA5)); chk("slip_relocked", locked, 1);
      step(uni(8'h5A));

      // randomized frames with random faults, gaps and ready
      rand_rdy = 1'b1;
      for (int f = 0; f < 24; f++) begin
         p[31:0]  = $urandom;
         p[63:32] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : p[31:0];
         kind  = $urandom_range(0, 4);
         cpf_v = 52 + 2 * $urandom_range(0, 14);
         j     = $urandom_range(0, NB - 1);
         case (kind)
            1: begin cc = $urandom_range(16, cpf_v - 5); j = $urandom_range(1, NB - 1); end
            2: cc = 16 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
            3: cc = $urandom_range(1, 15);
            4: cc = $urandom_range(cpf_v - 4, cpf_v - 1);
            default: cc = 0;
         endcase
         send_frame(p, kind, cc, j, 8'($urandom_range(1, 255)), cpf_v, 1'b0);
         gap = $urandom_range(0, 2);
         if (gap == 1) repeat ($urandom_range(1, 3)) idle_pair();
         else if (gap == 2) begin
            step(uni(8'h00));
            exp_slips++;
            idle_pair();
         end
      end
      rand_rdy = 1'b0;
      tready = 1'b1;
      repeat (2) idle_pair();
      chk("queue_drained", exp_q.size(), 0);
      check_counters("random");

      // clear_counters
      clear_counters = 1'b1;
      step(uni(8'hA5));
      clear_counters = 1'b0;
      exp_frames = 0; exp_errs = 0; exp_slips = 0; exp_drops = 0;
      check_counters("clear");
      step(uni(8'h5A));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sensor_frame_rx.md
Name: sensor_frame_rx

Overview:
- Receive-side decoder and checker for the sensor-emulator LVDS frame protocol.
- Locks to the idle pattern, tracks frame header, data and footer cycle by cycle, and verifies every cycle against protocol rules.
- Reconstructs the per-frame input pattern and emits it, with an error flag, on an AXI-Stream master.
- Sits at the far end of the LVDS link as the loopback checker for the emulator.

Parameters:
PATTERN_WIDTH, 32, width of the recovered pattern; legal values 8, 16, 32, 64.
LVDS_WIDTH, 512, LVDS bus width; multiple of 8; LVDS_BYTES = LVDS_WIDTH/8.

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
cycles_per_frame  input  32  clocks per frame; even and >= 52; static while locked
idle_0  input  8  expected first idle byte
idle_1  input  8  expected second idle byte; != idle_0
frame_header  input  32  expected header bytes; [7:0] must differ from idle_0 and idle_1
clear_counters  input  1  synchronous clear of all counters
lvds  input  LVDS_WIDTH  received LVDS bus
locked  output  1  high while in IDLE/HDR/DATA/FTR
sof  output  1  registered; pulses on cycle 0 of a frame
eof  output  1  registered; pulses on last footer cycle
frame_count  output  32  frames completed, saturating
error_count  output  32  frames with any error, saturating
sync_loss_count  output  32  lock losses, saturating
drop_count  output  32  results dropped by backpressure, saturating
M_AXIS_TDATA  output  PATTERN_WIDTH  recovered pattern
M_AXIS_TUSER  output  1  1 = frame had an error
M_AXIS_TVALID  output  1  result valid
M_AXIS_TREADY  input  1  downstream ready

Behaviour:
- Reset: all outputs and counters 0; FSM enters HUNT.
- Uniform bus: all LVDS_BYTES bytes are equal; U(b) means the bus is uniform with value b.
- HUNT: requires U(idle_0) followed by U(idle_1) on consecutive cycles, then enters IDLE (locked=1).
- IDLE: expects bus values alternating idle_0, idle_1. If the previous cycle was idle_1 and the bus is U(frame_header[7:0]), go to HDR with cyc=0 and pulse sof. Any other deviation: sync_loss_count++ and return to HUNT.
- cyc: 32-bit frame cycle counter, +1 per clock while in a frame.
- HDR (cyc 0..15):
  - cyc 1..3 must be U(frame_header[8*cyc +: 8]).
  - cyc 8 must have byte i = i[7:0].
  - All other header cycles must be 0.
  - A mismatch sets the frame error flag ferr; FSM stays in frame.
- DATA (cyc 16..cycles_per_frame-5):
  - Bus must be uniform, else ferr.
  - Slot index k = cyc[4:2].
  - For cyc 16..47, capture slot[k] on the first visit; later visits in the same frame must match slot[k], else ferr.
- FTR (last 4 cycles): bus must be 0, else ferr. eof pulses on cyc = cycles_per_frame-1.
- After the last footer cycle:
  - U(idle_0) goes to IDLE.
  - U(frame_header[7:0]) starts a back-to-back frame (cyc=0, sof).
  - Anything else: sync_loss_count++ and go to HUNT; the completed frame is still reported.
- Frame completion:
  - frame_count++; error_count++ if ferr.
  - The next cycle presents TDATA = {slot0..slot7}[PATTERN_WIDTH-1:0], with slot7 least significant, and TUSER = ferr.
  - If PATTERN_WIDTH < 64, the upper replicas must match the low replica, else TUSER=1 and error_count counts the frame.
- Handshake: TVALID is held with stable TDATA/TUSER until TREADY; it drops the cycle after a TVALID&TREADY transfer. A result arriving while TVALID=1 and TREADY=0 is discarded with drop_count++. Simultaneous transfer and new result: the new result is loaded and TVALID stays 1.
- Counters saturate at 0xFFFFFFFF. clear_counters wins over a same-cycle increment.
- Reset mid-frame: the partial frame is discarded with no output or count, and the FSM returns to HUNT.

Test Plan:
- Idle lock: alternate U(0xA5)/U(0x5A) with idle_0=0xA5, idle_1=0x5A -> locked=1 two cycles after the first U(0x5A) is presented; counters stay 0.
- Clean frame: cycles_per_frame=64, header=0x44332211, pattern 0xDEADBEEF -> sof at cyc 0, eof at cyc 63; TDATA=0xDEADBEEF, TUSER=0; frame_count=1, error_count=0.
- Corrupt data: flip one byte in cyc 20 -> TUSER=1, error_count=1, locked remains 1.
- Backpressure: two back-to-back frames with TREADY=0 -> first result held; drop_count=1; once TREADY=1, first TDATA transfers.
- Sync loss: inject U(0x00) in IDLE where idle_1 is expected -> sync_loss_count=1, locked=0; relock after the next idle pair.
- Reset mid-DATA at cyc 30 -> TVALID=0, frame_count unchanged, FSM in HUNT.
